bram_latency_mp: RTL and testbench
==================================

Name: bram_latency_mp

Overview:
- Multi-port simulation/test memory that models slow external storage, such as SDRAM or flash, behind the standard request/ready bus.
- Generalises the single-port latency BRAM with:
  - NPORTS requesters under round-robin arbitration;
  - separate read and write latencies;
  - optional pseudo-random latency jitter;
  - byte-masked writes;
  - request-abort handling.
- Used in benches and FPGA bring-up to stress bus masters and arbiters with realistic, non-constant latency.

Parameters:
- NPORTS, 2, number of requester ports (1..8).
- WIDTH, 32, data width in bits; must be a multiple of 8.
- SIZE, 32'h400, number of WIDTH-bit words.
- ADDR_LSH, 2, right shift applied to the byte address to form the word index.
- RLATENCY, 10, base wait cycles for reads (0..255).
- WLATENCY, 4, base wait cycles for writes (0..255).
- JITTER_BITS, 0, number of LFSR bits added to the latency (0..4); 0 disables jitter.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_request  in  NPORTS  per-port request; held high until o_ready.
- i_rw  in  NPORTS  per-port direction: 1 = write, 0 = read.
- i_address  in  NPORTS*32  per-port byte address; port p occupies [p*32 +: 32].
- i_wdata  in  NPORTS*WIDTH  per-port write data.
- i_wmask  in  NPORTS*(WIDTH/8)  per-port byte enables; bit b enables byte b.
- o_rdata  out  NPORTS*WIDTH  per-port registered read data.
- o_ready  out  NPORTS  per-port completion strobe, one cycle wide.
- o_valid  out  NPORTS  per-port address-in-range flag for the last completion.

Behaviour:
- Reset (asynchronous, i_reset_n low):
  - state = IDLE; o_ready = 0; o_rdata = 0; o_valid = all 1s;
  - wait counter = 0; last_grant = NPORTS-1, so port 0 wins first;
  - lfsr = SEED.
  - Memory contents are not reset.
- Reset mid-access abandons the access; no memory write occurs.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock while out of reset.
- FSM states:
  - IDLE:
    - If any i_request bit is high, grant the first requesting port searching upward from last_grant+1, wrapping modulo NPORTS.
    - Latch that port's rw, word index, wdata and wmask.
    - target = (rw ? WLATENCY : RLATENCY) + lfsr[JITTER_BITS-1:0] (jitter term is 0 when JITTER_BITS = 0).
    - counter = 0; last_grant = granted port; go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - If i_request[grant] = 0: abort. Go to IDLE, perform no write, raise no o_ready, leave outputs unchanged.
    - Else if counter == target: perform the access and go to DONE.
    - Else counter <= counter + 1.
  - DONE:
    - o_ready[grant] = 1 for exactly this cycle; go to IDLE unconditionally.
- Timing: the request is sampled at edge E0. o_ready is high from edge E0+target+1 to E0+target+2. Minimum request-to-ready is 2 cycles (target = 0).
- Access rules:
  - word = address >> ADDR_LSH; in range iff word < SIZE.
  - In-range write: only masked bytes are updated; o_rdata[grant] is unchanged; o_valid[grant] = 1.
  - In-range read: o_rdata[grant] = mem[word]; o_valid[grant] = 1.
  - Out of range: no write; o_rdata[grant] = 0; o_valid[grant] = 0.
  - Outputs of non-granted ports hold their values.
- Requester contract:
  - Keep i_request and the operands stable until o_ready.
  - Deassert i_request in the cycle after o_ready; otherwise the request is re-arbitrated as a new access.
- Only one access is in flight at a time. Requests from other ports wait; round-robin guarantees each waiting port is served within NPORTS grants.
- Counter width is 9 bits; 255 + 15 cannot overflow.

Test Plan:
- RLATENCY=10, JITTER_BITS=0: write 0xDEADBEEF to address 0x10 with mask 4'hF, then read 0x10 -> write o_ready at E0+5, read o_ready at E0+11, o_rdata = 0xDEADBEEF, o_valid = 1.
- Byte mask: write 0x11223344 to 0x20 with mask 4'hF, then 0xAABBCCDD with mask 4'b0101 -> read of 0x20 returns 0x11BB33DD.
- Out of range: read 0x1000 (word 0x400 = SIZE) -> o_ready after 11 cycles with o_valid = 0, o_rdata = 0; a write to 0x1000 leaves word 0 unchanged.
- Both ports request reads continuously from reset -> grants alternate 0,1,0,1; each o_ready is a single cycle and only the granted port's o_rdata changes.
- Abort: port 0 drops i_request 3 cycles into a write -> no o_ready, memory unchanged, port 1's pending request is granted the next cycle. Separately, pulse i_reset_n low mid-read -> o_ready = 0, o_valid = all 1s, FSM back to IDLE.
- JITTER_BITS=2, 200 reads -> every ready latency lies in [11,14] cycles, at least 3 distinct values observed, all data correct.

Source files
------------

// File: rtl/bram_latency_mp.sv
// bram_latency_mp
// Multi-port test memory that imitates slow external storage (SDRAM, flash)
// behind a request/ready bus. NPORTS requesters share one array under
// round-robin arbitration; reads and writes have separate base latencies,
// with optional pseudo-random jitter added from a free-running LFSR.
//
// Handshake: a requester raises i_request[p] with i_rw/i_address/i_wdata/
// i_wmask stable and holds it until o_ready[p] pulses for one cycle; it must
// drop i_request[p] in the cycle after o_ready, otherwise the still-high
// request is arbitrated again as a fresh access. Dropping i_request[p] while
// its access is in flight abandons that access: no write, no o_ready.
//
// Ports:
//   i_clock    clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_request  [NPORTS]            per-port request
//   i_rw       [NPORTS]            1 = write, 0 = read
//   i_address  [NPORTS*32]         per-port byte address
//   i_wdata    [NPORTS*WIDTH]      per-port write data
//   i_wmask    [NPORTS*WIDTH/8]    per-port byte enables
//   o_rdata    [NPORTS*WIDTH]      per-port registered read data
//   o_ready    [NPORTS]            per-port one-cycle completion strobe
//   o_valid    [NPORTS]            per-port address-in-range flag
//   o_state    [2]                 FSM state: 0 IDLE, 1 BUSY, 2 DONE
module bram_latency_mp #(
   parameter int          NPORTS      = 2,
   parameter int          WIDTH       = 32,
   parameter int          SIZE        = 32'h400,
   parameter int          ADDR_LSH    = 2,
   parameter int          RLATENCY    = 10,
   parameter int          WLATENCY    = 4,
   parameter int          JITTER_BITS = 0,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic                        i_clock,
   input  logic                        i_reset_n,
   input  logic [NPORTS-1:0]           i_request,
   input  logic [NPORTS-1:0]           i_rw,
   input  logic [NPORTS*32-1:0]        i_address,
   input  logic [NPORTS*WIDTH-1:0]     i_wdata,
   input  logic [NPORTS*(WIDTH/8)-1:0] i_wmask,
   output logic [NPORTS*WIDTH-1:0]     o_rdata,
   output logic [NPORTS-1:0]           o_ready,
   output logic [NPORTS-1:0]           o_valid,
   output logic [1:0]                  o_state
);

   localparam int NB = WIDTH / 8;
   localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]      mem [SIZE];
   logic [15:0]           lfsr;
   logic [8:0]            counter;
   logic [8:0]            target;
   logic [8:0]            jitter;
   logic [GW-1:0]         grant;
   logic [GW-1:0]         last_grant;
   logic [GW-1:0]         arb_port;
   logic                  arb_found;
   logic [2*NPORTS-1:0]   req_dbl;
   logic [NPORTS-1:0]     req_rot;
   logic                  g_rw;
   logic [31:0]           g_word;
   logic [WIDTH-1:0]      g_wdata;
   logic [NB-1:0]         g_wmask;
   logic                  req_held;
   logic                  in_range;
   logic                  access;

   assign o_state  = state;
   assign req_held = i_request[grant];
   assign in_range = (g_word < 32'(SIZE));
   assign access   = (state == BUSY) && req_held && (counter == target);

   // Jitter comes from the low LFSR bits at the moment of the grant.
   if (JITTER_BITS > 0) begin : g_jitter
      assign jitter = 9'(lfsr[JITTER_BITS-1:0]);
   end else begin : g_no_jitter
      assign jitter = '0;
   end

   // Round-robin: rotate the request vector so bit 0 is the port just after
   // last_grant, then take the lowest set bit.
   always_comb begin
      req_dbl   = {i_request, i_request};
      req_rot   = NPORTS'(req_dbl >> (int'(last_grant) + 1));
      arb_found = 1'b0;
      arb_port  = '0;
      for (int j = 0; j < NPORTS; j++) begin
         if (!arb_found && req_rot[j]) begin
            arb_found = 1'b1;
            arb_port  = GW'((int'(last_grant) + 1 + j) % NPORTS);
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (arb_found) state_next = BUSY;
         BUSY: begin
            if (!req_held)               state_next = IDLE;
            else if (counter == target)  state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         lfsr       <= SEED;
         counter    <= '0;
         target     <= '0;
         grant      <= '0;
         last_grant <= GW'(NPORTS - 1);
         g_rw       <= 1'b0;
         g_word     <= '0;
         g_wdata    <= '0;
         g_wmask    <= '0;
         o_ready    <= '0;
         o_rdata    <= '0;
         o_valid    <= '1;
      end else begin
         // Fibonacci LFSR, taps 16,14,13,11.
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         o_ready <= '0;

         if (state == IDLE && arb_found) begin
            grant      <= arb_port;
            last_grant <= arb_port;
            g_rw       <= i_rw[arb_port];
            g_word     <= i_address[int'(arb_port)*32 +: 32] >> ADDR_LSH;
            g_wdata    <= i_wdata[int'(arb_port)*WIDTH +: WIDTH];
            g_wmask    <= i_wmask[int'(arb_port)*NB +: NB];
            target     <= (i_rw[arb_port] ? 9'(WLATENCY) : 9'(RLATENCY)) + jitter;
            counter    <= '0;
         end

         if (state == BUSY && req_held && counter != target)
            counter <= counter + 9'd1;

         if (access) begin
            o_ready[grant] <= 1'b1;
            o_valid[grant] <= in_range;
            if (!in_range)
               o_rdata[int'(grant)*WIDTH +: WIDTH] <= '0;
            else if (!g_rw)
               o_rdata[int'(grant)*WIDTH +: WIDTH] <= mem[g_word[AW-1:0]];
         end
      end
   end

   // Array contents are deliberately not reset. A reset forces IDLE, so an
   // interrupted access never reaches the write.
   always_ff @(posedge i_clock) begin
      if (access && g_rw && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (g_wmask[b]) mem[g_word[AW-1:0]][b*8 +: 8] <= g_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_bram_latency_mp.sv
module tb_bram_latency_mp;

   localparam int NP        = 2;
   localparam int W         = 32;
   localparam int NB        = W / 8;
   localparam int MEM_WORDS = 32'h400;
   localparam int RLAT      = 10;
   localparam int WLAT      = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    req   = '0;
   logic [NP-1:0]    rw    = '0;
   logic [NP*32-1:0] addr  = '0;
   logic [NP*W-1:0]  wdata = '0;
   logic [NP*NB-1:0] wmask = '0;
   logic [NP*W-1:0]  rdata;
   logic [NP-1:0]    ready;
   logic [NP-1:0]    valid;
   logic [1:0]       st;

   logic [NP-1:0]    req_j   = '0;
   logic [NP-1:0]    rw_j    = '0;
   logic [NP*32-1:0] addr_j  = '0;
   logic [NP*W-1:0]  wdata_j = '0;
   logic [NP*NB-1:0] wmask_j = '0;
   logic [NP*W-1:0]  rdata_j;
   logic [NP-1:0]    ready_j;
   logic [NP-1:0]    valid_j;
   logic [1:0]       st_j;

   bram_latency_mp #(
      .NPORTS(NP), .WIDTH(W), .SIZE(MEM_WORDS), .ADDR_LSH(2),
      .RLATENCY(RLAT), .WLATENCY(WLAT), .JITTER_BITS(0), .SEED(16'hACE1)
   ) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw),
      .i_address(addr), .i_wdata(wdata), .i_wmask(wmask),
      .o_rdata(rdata), .o_ready(ready), .o_valid(valid), .o_state(st)
   );

   bram_latency_mp #(
      .NPORTS(NP), .WIDTH(W), .SIZE(MEM_WORDS), .ADDR_LSH(2),
      .RLATENCY(RLAT), .WLATENCY(WLAT), .JITTER_BITS(2), .SEED(16'hACE1)
   ) dut_j (
      .i_clock(clk), .i_reset_n(rst_n), .i_request(req_j), .i_rw(rw_j),
      .i_address(addr_j), .i_wdata(wdata_j), .i_wmask(wmask_j),
      .o_rdata(rdata_j), .o_ready(ready_j), .o_valid(valid_j), .o_state(st_j)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] ref_mem [int];
   logic [W-1:0] exp_rd [NP];
   logic         exp_v  [NP];
   logic [W-1:0] exp_q[$];

   function automatic void model_reset();
      for (int p = 0; p < NP; p++) begin
         exp_rd[p] = '0;
         exp_v[p]  = 1'b1;
      end
   endfunction

   // Returns the expected request-to-ready latency in edges after the grant.
   function automatic int model_access(input int p, input bit w, input logic [31:0] a,
                                       input logic [W-1:0] d, input logic [NB-1:0] m);
      logic [W-1:0] cur;
      int unsigned  word;
      word = a >> 2;
      if (word >= MEM_WORDS) begin
         exp_rd[p] = '0;
         exp_v[p]  = 1'b0;
      end else begin
         exp_v[p] = 1'b1;
         if (w) begin
            cur = ref_mem.exists(int'(word)) ? ref_mem[int'(word)] : 'x;
            for (int b = 0; b < NB; b++) if (m[b]) cur[b*8 +: 8] = d[b*8 +: 8];
            ref_mem[int'(word)] = cur;
         end else begin
            exp_rd[p] = ref_mem.exists(int'(word)) ? ref_mem[int'(word)] : 'x;
         end
      end
      return (w ? WLAT : RLAT) + 1;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again.
   task automatic access(input int p, input bit w, input logic [31:0] a,
                         input logic [W-1:0] d, input logic [NB-1:0] m,
                         output logic [W-1:0] rd, output logic v, output int lat,
                         output logic [NP-1:0] rdy_after);
      rw[p] = w;
      addr[p*32 +: 32] = a;
      wdata[p*W +: W] = d;
      wmask[p*NB +: NB] = m;
      req[p] = 1'b1;
      lat = -1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); @(negedge clk);
         if (ready[p]) begin lat = c; break; end
      end
      rd = rdata[p*W +: W];
      v  = valid[p];
      req[p] = 1'b0;
      @(negedge clk);
      rdy_after = ready;
   endtask

   task automatic jaccess(input bit w, input logic [31:0] a, input logic [W-1:0] d,
                          output logic [W-1:0] rd, output logic v, output int lat);
      rw_j[0] = w;
      addr_j[31:0] = a;
      wdata_j[W-1:0] = d;
      wmask_j[NB-1:0] = '1;
      req_j[0] = 1'b1;
      lat = -1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); @(negedge clk);
         if (ready_j[0]) begin lat = c; break; end
      end
      rd = rdata_j[W-1:0];
      v  = valid_j[0];
      req_j[0] = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", ready); else n_pass++;
      n_checks++; if (valid !== 2'b11) $display("FAIL rst_valid: got %b expected 11", valid); else n_pass++;
      n_checks++; if (rdata !== '0) $display("FAIL rst_rdata: got %h expected 0", rdata); else n_pass++;
      n_checks++; if (st !== 2'd0) $display("FAIL rst_state: got %0d expected 0", st); else n_pass++;
      n_checks++; if (valid_j !== 2'b11) $display("FAIL rst_valid_j: got %b expected 11", valid_j); else n_pass++;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      e_lat = model_access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
      access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, v, lat, ra);
      n_checks++; if (lat !== 5) $display("FAIL basic_wr_lat: got %0d expected %0d", lat, 5); else n_pass++;
      n_checks++; if (v !== 1'b1) $display("FAIL basic_wr_valid: got %b expected 1", v); else n_pass++;
      n_checks++; if (rd !== exp_rd[0]) $display("FAIL basic_wr_rdata_hold: got %h expected %h", rd, exp_rd[0]); else n_pass++;
      n_checks++; if (ra !== 2'b00) $display("FAIL basic_ready_pulse: got %b expected 00", ra); else n_pass++;
      e_lat = model_access(0, 0, 32'h10, '0, '0);
      access(0, 0, 32'h10, '0, '0, rd, v, lat, ra);
      n_checks++; if (lat !== e_lat) $display("FAIL basic_rd_lat: got %0d expected %0d", lat, e_lat); else n_pass++;
      n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data: got %h expected deadbeef", rd); else n_pass++;
      n_checks++; if (v !== 1'b1) $display("FAIL basic_rd_valid: got %b expected 1", v); else n_pass++;
   endtask

   task automatic test_mask();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      e_lat = model_access(1, 1, 32'h20, 32'h11223344, 4'hF);
      access(1, 1, 32'h20, 32'h11223344, 4'hF, rd, v, lat, ra);
      e_lat = model_access(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
      access(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, v, lat, ra);
      n_checks++; if (lat !== e_lat) $display("FAIL mask_wr_lat: got %0d expected %0d", lat, e_lat); else n_pass++;
      e_lat = model_access(1, 0, 32'h20, '0, '0);
      access(1, 0, 32'h20, '0, '0, rd, v, lat, ra);
      n_checks++; if (rd !== 32'h11BB33DD) $display("FAIL mask_rd_data: got %h expected 11bb33dd", rd); else n_pass++;
      n_checks++; if (rd !== exp_rd[1]) $display("FAIL mask_rd_model: got %h expected %h", rd, exp_rd[1]); else n_pass++;
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      e_lat = model_access(0, 1, 32'h0, 32'hCAFEF00D, 4'hF);
      access(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, rd, v, lat, ra);
      e_lat = model_access(0, 0, 32'h1000, '0, '0);
      access(0, 0, 32'h1000, '0, '0, rd, v, lat, ra);
      n_checks++; if (lat !== 11) $display("FAIL oor_rd_lat: got %0d expected 11", lat); else n_pass++;
      n_checks++; if (v !== 1'b0) $display("FAIL oor_rd_valid: got %b expected 0", v); else n_pass++;
      n_checks++; if (rd !== '0) $display("FAIL oor_rd_data: got %h expected 0", rd); else n_pass++;
      e_lat = model_access(0, 1, 32'h1000, 32'h12345678, 4'hF);
      access(0, 1, 32'h1000, 32'h12345678, 4'hF, rd, v, lat, ra);
      n_checks++; if (v !== 1'b0) $display("FAIL oor_wr_valid: got %b expected 0", v); else n_pass++;
      e_lat = model_access(0, 0, 32'h0, '0, '0);
      access(0, 0, 32'h0, '0, '0, rd, v, lat, ra);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL oor_word0_kept: got %h expected cafef00d", rd); else n_pass++;
      n_checks++; if (v !== 1'b1) $display("FAIL oor_word0_valid: got %b expected 1", v); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      e_lat = model_access(1, 0, 32'h1000, '0, '0);
      access(1, 0, 32'h1000, '0, '0, rd, v, lat, ra);
      // Write to word 0 interrupted by reset after two cycles of waiting.
      rw[0] = 1'b1; addr[31:0] = 32'h0; wdata[W-1:0] = 32'h0BADBAD0; wmask[NB-1:0] = 4'hF;
      req[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (ready !== 2'b00) $display("FAIL midrst_ready: got %b expected 00", ready); else n_pass++;
      n_checks++; if (valid !== 2'b11) $display("FAIL midrst_valid: got %b expected 11", valid); else n_pass++;
      n_checks++; if (rdata !== '0) $display("FAIL midrst_rdata: got %h expected 0", rdata); else n_pass++;
      n_checks++; if (st !== 2'd0) $display("FAIL midrst_state: got %0d expected 0", st); else n_pass++;
      req[0] = 1'b0;
      @(negedge clk); rst_n = 1'b1; model_reset();
      @(negedge clk);
      e_lat = model_access(0, 0, 32'h0, '0, '0);
      access(0, 0, 32'h0, '0, '0, rd, v, lat, ra);
      n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL midrst_no_write: got %h expected cafef00d", rd); else n_pass++;
      // Read interrupted by reset.
      rw[1] = 1'b0; addr[63:32] = 32'h10; req[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (st !== 2'd0) $display("FAIL midrst_rd_state: got %0d expected 0", st); else n_pass++;
      n_checks++; if (valid !== 2'b11) $display("FAIL midrst_rd_valid: got %b expected 11", valid); else n_pass++;
      req[1] = 1'b0;
      @(negedge clk); rst_n = 1'b1; model_reset();
      @(negedge clk);
   endtask

   task automatic test_abort();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      int  r1_at;
      bit  r0_seen;
      e_lat = model_access(0, 1, 32'h40, 32'h55AA55AA, 4'hF);
      access(0, 1, 32'h40, 32'h55AA55AA, 4'hF, rd, v, lat, ra);
      e_lat = model_access(1, 1, 32'h44, 32'h01020304, 4'hF);
      access(1, 1, 32'h44, 32'h01020304, 4'hF, rd, v, lat, ra);
      rw[0] = 1'b1; addr[31:0] = 32'h40; wdata[W-1:0] = 32'hFFFFFFFF; wmask[NB-1:0] = 4'hF;
      req[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      rw[1] = 1'b0; addr[63:32] = 32'h44; req[1] = 1'b1;
      r1_at = -1; r0_seen = 1'b0;
      for (int c = 1; c < 60; c++) begin
         @(posedge clk); @(negedge clk);
         if (ready[0]) r0_seen = 1'b1;
         if (c == 3) req[0] = 1'b0;
         if (c == 4) begin
            n_checks++; if (st !== 2'd0) $display("FAIL abort_idle: got %0d expected 0", st); else n_pass++;
         end
         if (c == 5) begin
            n_checks++; if (st !== 2'd1) $display("FAIL abort_regrant: got %0d expected 1", st); else n_pass++;
         end
         if (ready[1]) begin r1_at = c; break; end
      end
      e_lat = model_access(1, 0, 32'h44, '0, '0);
      n_checks++; if (r0_seen !== 1'b0) $display("FAIL abort_no_ready: got %b expected 0", r0_seen); else n_pass++;
      n_checks++; if (r1_at !== 16) $display("FAIL abort_p1_lat: got %0d expected 16", r1_at); else n_pass++;
      n_checks++; if (rdata[63:32] !== exp_rd[1]) $display("FAIL abort_p1_data: got %h expected %h", rdata[63:32], exp_rd[1]); else n_pass++;
      req[1] = 1'b0;
      @(negedge clk);
      e_lat = model_access(0, 0, 32'h40, '0, '0);
      access(0, 0, 32'h40, '0, '0, rd, v, lat, ra);
      n_checks++; if (rd !== 32'h55AA55AA) $display("FAIL abort_mem_kept: got %h expected 55aa55aa", rd); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      int ports[$];
      int times[$];
      logic [NP-1:0] prev;
      int p, o;
      e_lat = model_access(0, 1, 32'h30, 32'hA0A0A0A0, 4'hF);
      access(0, 1, 32'h30, 32'hA0A0A0A0, 4'hF, rd, v, lat, ra);
      e_lat = model_access(1, 1, 32'h34, 32'hB1B1B1B1, 4'hF);
      access(1, 1, 32'h34, 32'hB1B1B1B1, 4'hF, rd, v, lat, ra);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_reset(); @(negedge clk);
      rw = 2'b00; addr = {32'h34, 32'h30}; req = 2'b11;
      prev = '0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); @(negedge clk);
         if (ready == 2'b11) begin
            n_checks++; $display("FAIL rr_one_hot: got %b expected one port", ready);
         end
         if ((ready & prev) != '0) begin
            n_checks++; $display("FAIL rr_pulse_width: got %b twice expected single cycle", ready);
         end
         if (ready != '0) begin
            p = ready[0] ? 0 : 1;
            o = 1 - p;
            e_lat = model_access(p, 0, (p == 0) ? 32'h30 : 32'h34, '0, '0);
            exp_q.push_back(exp_rd[p]);
            ports.push_back(p);
            times.push_back(c);
            rd = exp_q.pop_front();
            n_checks++; if (rdata[p*W +: W] !== rd) $display("FAIL rr_data: got %h expected %h", rdata[p*W +: W], rd); else n_pass++;
            n_checks++; if (rdata[o*W +: W] !== exp_rd[o]) $display("FAIL rr_other_hold: got %h expected %h", rdata[o*W +: W], exp_rd[o]); else n_pass++;
            if (ports.size() == 4) begin req = 2'b00; break; end
         end
         prev = ready;
      end
      @(negedge clk);
      n_checks++; if (ports.size() !== 4) $display("FAIL rr_count: got %0d expected 4", ports.size()); else n_pass++;
      if (ports.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            n_checks++; if (ports[i] !== (i % 2)) $display("FAIL rr_order: got %0d expected %0d", ports[i], i % 2); else n_pass++;
            n_checks++; if (times[i] !== 11 + 13*i) $display("FAIL rr_timing: got %0d expected %0d", times[i], 11 + 13*i); else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] rd; logic v; int lat; logic [NP-1:0] ra; int e_lat;
      logic [W-1:0] d; logic [NB-1:0] m; logic [31:0] a;
      int p, o; bit w;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         e_lat = model_access(i % 2, 1, 32'h100 + 32'(4*i), d, 4'hF);
         access(i % 2, 1, 32'h100 + 32'(4*i), d, 4'hF, rd, v, lat, ra);
      end
      for (int n = 0; n < 40; n++) begin
         p = $urandom_range(0, 1);
         o = 1 - p;
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         m = NB'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 32'hFFFF));
         else a = 32'h100 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         e_lat = model_access(p, w, a, d, m);
         exp_q.push_back(exp_rd[p]);
         access(p, w, a, d, m, rd, v, lat, ra);
         n_checks++; if (lat !== e_lat) $display("FAIL rand_lat: got %0d expected %0d", lat, e_lat); else n_pass++;
         n_checks++; if (rd !== exp_q[0]) $display("FAIL rand_rdata: got %h expected %h", rd, exp_q[0]); else n_pass++;
         void'(exp_q.pop_front());
         n_checks++; if (v !== exp_v[p]) $display("FAIL rand_valid: got %b expected %b", v, exp_v[p]); else n_pass++;
         n_checks++; if (rdata[o*W +: W] !== exp_rd[o]) $display("FAIL rand_other_hold: got %h expected %h", rdata[o*W +: W], exp_rd[o]); else n_pass++;
         n_checks++; if (ra !== 2'b00) $display("FAIL rand_ready_pulse: got %b expected 00", ra); else n_pass++;
      end
   endtask

   task automatic test_jitter();
      logic [W-1:0] jmem [8];
      logic [W-1:0] rd; logic v; int lat; int k;
      logic [15:0] seen;
      seen = '0;
      for (int i = 0; i < 8; i++) begin
         jmem[i] = $urandom;
         jaccess(1'b1, 32'h200 + 32'(4*i), jmem[i], rd, v, lat);
         n_checks++; if (lat < 5 || lat > 8) $display("FAIL jit_wr_lat: got %0d expected 5..8", lat); else n_pass++;
      end
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 7);
         jaccess(1'b0, 32'h200 + 32'(4*k), '0, rd, v, lat);
         n_checks++; if (lat < 11 || lat > 14) $display("FAIL jit_rd_lat: got %0d expected 11..14", lat); else n_pass++;
         n_checks++; if (rd !== jmem[k]) $display("FAIL jit_rd_data: got %h expected %h", rd, jmem[k]); else n_pass++;
         n_checks++; if (v !== 1'b1) $display("FAIL jit_rd_valid: got %b expected 1", v); else n_pass++;
         if (lat >= 0 && lat < 16) seen[lat] = 1'b1;
      end
      n_checks++; if ($countones(seen) < 3) $display("FAIL jit_distinct: got %0d expected >=3", $countones(seen)); else n_pass++;
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_mask();
      test_out_of_range();
      test_reset_mid();
      test_abort();
      test_round_robin();
      test_random();
      test_jitter();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
